// File: rtl/tof_pkg.sv
// Shared types and constants for the ToF ranging blocks: sequencer state encoding,
// register map defaults and the inter-block command codes.
package tof_pkg;

  localparam logic [15:0] DataStartAddrDefault = 16'h0400;
  localparam int unsigned DistWidth            = 14;

  typedef enum logic [1:0] {
    CmdNone = 2'd0,
    CmdDone = 2'd1,
    CmdAck  = 2'd2
  } tof_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StReqMsb,
    StWaitMsb,
    StReqLsb,
    StWaitLsb,
    StEmit,
    StError
  } tof_state_e;

  // Each zone occupies two consecutive byte registers, MSB first; wraps modulo 2^16.
  function automatic logic [15:0] zone_addr(logic [15:0] base, logic [5:0] zone, logic lsb);
    return base + {9'b0, zone, lsb};
  endfunction

endpackage

// File: rtl/tof_ranging_sequencer_if.sv
// Byte-read request/response channel between the ranging sequencer and the I2C master.
interface tof_ranging_sequencer_if;
  logic        start;
  logic        is_read;
  logic [15:0] register_address;
  logic [16:0] nb_of_bytes;
  logic        ready;
  logic        error_in;
  logic [7:0]  i2c_data_in;

  modport master (
    output start, is_read, register_address, nb_of_bytes,
    input  ready, error_in, i2c_data_in
  );

  modport slave (
    input  start, is_read, register_address, nb_of_bytes,
    output ready, error_in, i2c_data_in
  );
endinterface

// File: rtl/tof_int_arbiter.sv
// Per-sensor interrupt edge detection, pending latches, overrun counting and
// round-robin selection of the next sensor to service.
module tof_int_arbiter #(
  parameter int unsigned N_SENSORS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SENSORS-1:0] tof_int,
  input  logic                 grant,
  output logic                 any_pending,
  output logic [1:0]           sel,
  output logic [7:0]           overrun_cnt
);

  localparam int Ns = int'(N_SENSORS);

  logic [N_SENSORS-1:0] int_q, pending_q, pending_d, rise, clr, lost;
  logic [1:0]           ptr_q, ptr_d;
  logic [7:0]           overrun_d;
  int unsigned          ovr_sum;

  assign rise = tof_int & ~int_q;

  // Scan offsets from the far end so the sensor closest to the pointer wins.
  always_comb begin
    any_pending = 1'b0;
    sel         = '0;
    for (int off = Ns - 1; off >= 0; off--) begin
      for (int s = 0; s < Ns; s++) begin
        if (pending_q[s] && (((int'(ptr_q) + off) % Ns) == s)) begin
          any_pending = 1'b1;
          sel         = 2'(s);
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < Ns; s++) begin
      clr[s] = grant && (sel == 2'(s));
    end
    // An edge on a sensor being granted this cycle re-arms it rather than being lost.
    lost      = rise & pending_q & ~clr;
    pending_d = (pending_q & ~clr) | rise;
    ptr_d     = grant ? 2'((int'(sel) + 1) % Ns) : ptr_q;
    ovr_sum   = 32'(overrun_cnt) + 32'($countones(lost));
    overrun_d = (ovr_sum > 32'd255) ? 8'hFF : 8'(ovr_sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_q       <= '0;
      pending_q   <= '0;
      ptr_q       <= '0;
      overrun_cnt <= '0;
    end else begin
      int_q       <= tof_int;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      overrun_cnt <= overrun_d;
    end
  end

endmodule

// File: rtl/tof_ranging_sequencer.sv
// Services ToF sensor interrupts by reading every zone distance of a frame, one byte
// per I2C transaction, and emitting assembled distances with frame and error status.
module tof_ranging_sequencer
  import tof_pkg::*;
#(
  parameter int unsigned N_SENSORS       = 1,
  parameter int unsigned N_ZONES         = 64,
  parameter logic [15:0] DATA_START_ADDR = DataStartAddrDefault,
  parameter int unsigned TIMEOUT_CYC     = 100000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_err,
  input  logic [N_SENSORS-1:0]     ToF_INT,
  tof_ranging_sequencer_if.master  bus,
  output logic [1:0]               sensor_sel,
  output logic [DistWidth-1:0]     distance_data,
  output logic [5:0]               zone_index,
  output logic                     data_valid,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     err_flag,
  output logic [7:0]               overrun_cnt
);

  localparam int unsigned       TimerW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYC - 1);
  localparam logic [5:0]        LastZone  = 6'(N_ZONES - 1);

  tof_state_e           state_q, state_d;
  logic [5:0]           zone_q, zone_d;
  logic [1:0]           sensor_q, sensor_d;
  logic [DistWidth-1:0] dist_q, dist_d;
  logic                 start_q, start_d;
  logic [15:0]          addr_q, addr_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic                 err_q, err_d;
  logic                 grant, any_pending, enter_err;
  logic [1:0]           arb_sel;

  tof_int_arbiter #(
    .N_SENSORS (N_SENSORS)
  ) u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .tof_int     (ToF_INT),
    .grant       (grant),
    .any_pending (any_pending),
    .sel         (arb_sel),
    .overrun_cnt (overrun_cnt)
  );

  always_comb begin
    state_d    = state_q;
    zone_d     = zone_q;
    sensor_d   = sensor_q;
    dist_d     = dist_q;
    start_d    = start_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    grant      = 1'b0;
    enter_err  = 1'b0;
    data_valid = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: if (enable) state_d = StArm;
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (any_pending) begin
          grant    = 1'b1;
          sensor_d = arb_sel;
          zone_d   = '0;
          state_d  = StReqMsb;
        end
      end
      StReqMsb: begin
        start_d = 1'b1;
        addr_d  = zone_addr(DATA_START_ADDR, zone_q, 1'b0);
        timer_d = '0;
        state_d = StWaitMsb;
      end
      StWaitMsb: begin
        // error_in is checked first so it wins over a coincident ready.
        if (bus.error_in) begin
          enter_err = 1'b1;
        end else if (bus.ready) begin
          start_d                     = 1'b0;
          dist_d[DistWidth-1 -: 8]    = bus.i2c_data_in;
          state_d                     = StReqLsb;
        end else if (timer_q == TimerLast) begin
          enter_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StReqLsb: begin
        start_d = 1'b1;
        addr_d  = zone_addr(DATA_START_ADDR, zone_q, 1'b1);
        timer_d = '0;
        state_d = StWaitLsb;
      end
      StWaitLsb: begin
        if (bus.error_in) begin
          enter_err = 1'b1;
        end else if (bus.ready) begin
          start_d                = 1'b0;
          dist_d[DistWidth-9:0]  = bus.i2c_data_in[7:2];
          state_d                = StEmit;
        end else if (timer_q == TimerLast) begin
          enter_err = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StEmit: begin
        data_valid = 1'b1;
        if (zone_q == LastZone) begin
          frame_done = 1'b1;
          zone_d     = '0;
          state_d    = enable ? StArm : StIdle;
        end else begin
          zone_d  = zone_q + 1'b1;
          state_d = StReqMsb;
        end
      end
      StError: begin
        zone_d  = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (enter_err) begin
      start_d = 1'b0;
      zone_d  = '0;
      state_d = StError;
    end
  end

  // A new error outranks a coincident clear so it is never silently lost.
  always_comb begin
    err_d = err_q;
    if (clear_err) err_d = 1'b0;
    if (enter_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      zone_q   <= '0;
      sensor_q <= '0;
      dist_q   <= '0;
      start_q  <= 1'b0;
      addr_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      zone_q   <= zone_d;
      sensor_q <= sensor_d;
      dist_q   <= dist_d;
      start_q  <= start_d;
      addr_q   <= addr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign bus.start            = start_q;
  assign bus.is_read          = start_q;
  assign bus.register_address = addr_q;
  assign bus.nb_of_bytes      = '0;
  assign sensor_sel           = sensor_q;
  assign distance_data        = dist_q;
  assign zone_index           = zone_q;
  assign err_flag             = err_q;
  assign busy                 = (state_q != StIdle) && (state_q != StArm);

endmodule

// File: tb/tb_tof_ranging_sequencer.sv
// Self-checking bench for tof_ranging_sequencer: I2C slave responder, output monitor
// and a frame-level reference model of sensor order and zone distances.
module tb_tof_ranging_sequencer;
  localparam int NS = 3;
  localparam int NZ = 16;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        reset, enable, clear_err;
  logic [2:0]  tof_int;
  logic [1:0]  sensor_sel;
  logic [13:0] distance_data;
  logic [5:0]  zone_index;
  logic        data_valid, frame_done, busy, err_flag;
  logic [7:0]  overrun_cnt;

  tof_ranging_sequencer_if bus();

  tof_ranging_sequencer #(
    .N_SENSORS   (NS),
    .N_ZONES     (NZ),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear_err     (clear_err),
    .ToF_INT       (tof_int),
    .bus           (bus),
    .sensor_sel    (sensor_sel),
    .distance_data (distance_data),
    .zone_index    (zone_index),
    .data_valid    (data_valid),
    .frame_done    (frame_done),
    .busy          (busy),
    .err_flag      (err_flag),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  s;
    logic [5:0]  z;
    logic [13:0] d;
  } dv_t;

  int checks = 0;
  int errors = 0;
  bit fixed_bytes, mute, inject_err;
  logic [15:0] err_addr;
  logic [7:0]  key;
  dv_t         dv_log[$];
  logic [15:0] addr_log[$];
  int fd_cnt, fd_zone_bad, proto_bad, lat_bad;

  function automatic logic [7:0] byte_for(input logic [15:0] a);
    if (fixed_bytes) return a[0] ? 8'hFC : 8'h12;
    return (a[7:0] * 8'd37) ^ key;
  endfunction

  function automatic logic [13:0] exp_dist(input int z);
    logic [7:0] m, l;
    m = byte_for(16'h0400 + 16'(2 * z));
    l = byte_for(16'h0401 + 16'(2 * z));
    return {m, l[7:2]};
  endfunction

  // I2C slave: answers each request 10 cycles after start is seen.
  initial begin : bfm
    int cnt;
    bit act;
    logic [15:0] a;
    bus.ready = 1'b0; bus.error_in = 1'b0; bus.i2c_data_in = 8'h00;
    act = 0; cnt = 0; a = '0;
    forever begin
      @(negedge clk);
      bus.ready = 1'b0;
      bus.error_in = 1'b0;
      if (reset) begin
        act = 0;
      end else if (act) begin
        if (cnt == 0) begin
          act = 0;
          bus.ready = 1'b1;
          bus.i2c_data_in = byte_for(a);
          if (inject_err && a == err_addr) bus.error_in = 1'b1;
        end else begin
          cnt--;
        end
      end else if (bus.start && !mute) begin
        act = 1; cnt = 9; a = bus.register_address;
      end
    end
  end

  initial begin : mon
    logic rdy_prev, st_prev;
    dv_t e;
    rdy_prev = 1'b0; st_prev = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        rdy_prev = 1'b0; st_prev = 1'b0;
      end else begin
        if (data_valid) begin
          e.s = sensor_sel; e.z = zone_index; e.d = distance_data;
          dv_log.push_back(e);
          if (!rdy_prev) lat_bad++;
        end
        if (frame_done) begin
          fd_cnt++;
          if (!data_valid || zone_index != 6'(NZ - 1)) fd_zone_bad++;
        end
        if (bus.start && !st_prev) addr_log.push_back(bus.register_address);
        if (bus.start && (bus.is_read !== 1'b1 || bus.nb_of_bytes !== 17'd0)) proto_bad++;
        if (rdy_prev && bus.start) proto_bad++;
        rdy_prev = bus.ready; st_prev = bus.start;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  task automatic clear_logs();
    dv_log.delete(); addr_log.delete(); fd_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; tof_int = '0;
    mute = 0; inject_err = 0; fixed_bytes = 0; key = '0; err_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic pulse_int(input logic [2:0] mask);
    @(negedge clk); tof_int = mask;
    @(negedge clk); tof_int = '0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_cnt >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clear_err = 1'b0; tof_int = '0;
    mute = 0; inject_err = 0; fixed_bytes = 0;
    #1;
    checks++;
    if ({bus.start, bus.is_read, bus.register_address, bus.nb_of_bytes} !== 35'd0) begin
      errors++;
      $display("FAIL reset_bus: got start=%b rd=%b addr=%h nb=%h required all 0",
               bus.start, bus.is_read, bus.register_address, bus.nb_of_bytes);
    end
    checks++;
    if ({data_valid, frame_done, busy, err_flag} !== 4'd0) begin
      errors++;
      $display("FAIL reset_status: got dv=%b fd=%b busy=%b err=%b required 0",
               data_valid, frame_done, busy, err_flag);
    end
    checks++;
    if ({distance_data, zone_index, sensor_sel, overrun_cnt} !== 30'd0) begin
      errors++;
      $display("FAIL reset_data: got dist=%h zone=%0d sel=%0d ovr=%0d required 0",
               distance_data, zone_index, sensor_sel, overrun_cnt);
    end
    do_reset();
    enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.start !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_int: got busy=%b start=%b required 0 0", busy, bus.start);
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    dv_t exp;
    do_reset();
    fixed_bytes = 1; enable = 1'b1;
    pulse_int(3'b001);
    wait_frames(1, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_wait: got no frame_done required 1"); end
    repeat (30) @(negedge clk);
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL single_fd_count: got %0d required 1", fd_cnt);
    end
    checks++;
    if (dv_log.size() != NZ) begin
      errors++; $display("FAIL single_dv_count: got %0d required %0d", dv_log.size(), NZ);
    end
    for (int i = 0; i < dv_log.size() && i < NZ; i++) begin
      exp.s = 2'd0; exp.z = 6'(i); exp.d = 14'h4BF;
      checks++;
      if (dv_log[i] !== exp) begin
        errors++; $display("FAIL single_dv[%0d]: got %h required %h", i, dv_log[i], exp);
      end
    end
    checks++;
    if (addr_log.size() != 2 * NZ) begin
      errors++; $display("FAIL single_addr_count: got %0d required %0d", addr_log.size(), 2 * NZ);
    end
    for (int i = 0; i < addr_log.size() && i < 2 * NZ; i++) begin
      checks++;
      if (addr_log[i] !== 16'h0400 + 16'(i)) begin
        errors++;
        $display("FAIL single_addr[%0d]: got %h required %h", i, addr_log[i], 16'h0400 + 16'(i));
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int ptr, n;
    int order[$];
    logic [2:0] mask, pend;
    dv_t exp;
    do_reset();
    enable = 1'b1;
    ptr = 0;
    for (int r = 0; r < 4; r++) begin
      mask = (r == 0) ? 3'b101 : 3'($urandom_range(1, 7));
      key = 8'($urandom);
      clear_logs();
      order.delete();
      pend = mask;
      while (pend != 0) begin
        for (int k = 0; k < NS; k++) begin
          int s;
          s = (ptr + k) % NS;
          if (pend[s]) begin
            order.push_back(s); pend[s] = 1'b0; ptr = (s + 1) % NS;
            break;
          end
        end
      end
      n = order.size();
      pulse_int(mask);
      wait_frames(n, 1000 * n, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rr_wait round %0d: got %0d frames required %0d", r, fd_cnt, n);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (dv_log.size() != n * NZ) begin
        errors++;
        $display("FAIL rr_dv_count round %0d: got %0d required %0d", r, dv_log.size(), n * NZ);
      end
      for (int i = 0; i < dv_log.size() && i < n * NZ; i++) begin
        exp.s = 2'(order[i / NZ]); exp.z = 6'(i % NZ); exp.d = exp_dist(i % NZ);
        checks++;
        if (dv_log[i] !== exp) begin
          errors++;
          $display("FAIL rr_dv round %0d [%0d]: got %h required %h", r, i, dv_log[i], exp);
        end
      end
      for (int i = 0; i < addr_log.size() && i < 2 * n * NZ; i++) begin
        checks++;
        if (addr_log[i] !== 16'h0400 + 16'(i % (2 * NZ))) begin
          errors++;
          $display("FAIL rr_addr round %0d [%0d]: got %h required %h", r, i, addr_log[i],
                   16'h0400 + 16'(i % (2 * NZ)));
        end
      end
      checks++;
      if (overrun_cnt !== 8'd0) begin
        errors++; $display("FAIL rr_overrun round %0d: got %0d required 0", r, overrun_cnt);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    enable = 1'b1;
    pulse_int(3'b001);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ovr_busy: got busy=0 required 1"); end
    pulse_int(3'b001);
    pulse_int(3'b001);
    repeat (3) @(negedge clk);
    checks++;
    if (overrun_cnt !== 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovr_count: got ovr=%0d busy=%b required 1 1", overrun_cnt, busy);
    end
    wait_frames(2, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovr_wait: got %0d frames required 2", fd_cnt); end
    repeat (600) @(negedge clk);
    checks++;
    if (fd_cnt != 2 || dv_log.size() != 2 * NZ || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovr_frames: got fd=%0d dv=%0d busy=%b required 2 %0d 0",
               fd_cnt, dv_log.size(), busy, 2 * NZ);
    end
  endtask

  task automatic test_error();
    bit ok;
    do_reset();
    enable = 1'b1; inject_err = 1; err_addr = 16'h0400 + 16'd11;
    pulse_int(3'b001);
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #2;
      if (bus.error_in) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL err_wait: got no error_in required 1"); end
    @(negedge clk); #2;
    checks++;
    if (bus.start !== 1'b0 || err_flag !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_next: got start=%b err=%b dv=%b required 0 1 0",
               bus.start, err_flag, data_valid);
    end
    @(negedge clk); #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL err_idle: got busy=%b required 0", busy); end
    repeat (30) @(negedge clk);
    checks++;
    if (fd_cnt != 0 || dv_log.size() != 5 || err_flag !== 1'b1) begin
      errors++;
      $display("FAIL err_partial: got fd=%0d dv=%0d err=%b required 0 5 1",
               fd_cnt, dv_log.size(), err_flag);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    #2;
    checks++;
    if (err_flag !== 1'b0) begin
      errors++; $display("FAIL err_clear: got err=%b required 0", err_flag);
    end
    inject_err = 0;
    clear_logs();
    pulse_int(3'b001);
    wait_frames(1, 1500, ok);
    checks++;
    if (!ok || addr_log.size() == 0 || addr_log[0] !== 16'h0400 || dv_log.size() != NZ) begin
      errors++;
      $display("FAIL err_restart: got ok=%b first=%h dv=%0d required 1 0400 %0d", ok,
               (addr_log.size() != 0) ? addr_log[0] : 16'hxxxx, dv_log.size(), NZ);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    do_reset();
    enable = 1'b1; mute = 1;
    pulse_int(3'b001);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.start) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL to_start: got start=0 required 1"); end
    cnt = ok ? 1 : 0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (bus.start) cnt++;
      else break;
    end
    checks++;
    if (cnt != TO) begin errors++; $display("FAIL to_cycles: got %0d required %0d", cnt, TO); end
    checks++;
    if (err_flag !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL to_error: got err=%b busy=%b required 1 1", err_flag, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fd_cnt != 0) begin
      errors++; $display("FAIL to_idle: got busy=%b fd=%0d required 0 0", busy, fd_cnt);
    end
    mute = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    enable = 1'b1;
    pulse_int(3'b001);
    ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (dv_log.size() >= 3 && bus.start) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_wait: got no start after zone 2 required 1"); end
    reset = 1'b1;
    tof_int = 3'b010;
    #1;
    checks++;
    if (bus.start !== 1'b0 || busy !== 1'b0 || bus.register_address !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async: got start=%b busy=%b addr=%h required 0 0 0000",
               bus.start, busy, bus.register_address);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    wait_frames(1, 1500, ok);
    tof_int = '0;
    checks++;
    if (!ok || dv_log.size() != NZ) begin
      errors++;
      $display("FAIL mid_frame: got ok=%b dv=%0d required 1 %0d", ok, dv_log.size(), NZ);
    end
    checks++;
    if (dv_log.size() == 0 || dv_log[0].s !== 2'd1 || dv_log[0].z !== 6'd0 ||
        addr_log.size() == 0 || addr_log[0] !== 16'h0400) begin
      errors++;
      $display("FAIL mid_restart: got first dv=%h addr=%h required sensor 1 zone 0 addr 0400",
               (dv_log.size() != 0) ? dv_log[0] : 22'hx,
               (addr_log.size() != 0) ? addr_log[0] : 16'hx);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_bad != 0) begin
      errors++; $display("FAIL protocol: got %0d violations required 0", proto_bad);
    end
    checks++;
    if (lat_bad != 0) begin
      errors++; $display("FAIL dv_latency: got %0d late pulses required 0", lat_bad);
    end
    checks++;
    if (fd_zone_bad != 0) begin
      errors++; $display("FAIL fd_alignment: got %0d misaligned required 0", fd_zone_bad);
    end
  endtask

  initial begin
    fd_zone_bad = 0; proto_bad = 0; lat_bad = 0; fd_cnt = 0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_overrun();
    test_error();
    test_timeout();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
